// File: rtl/multi_edge_det.sv
// Per-channel debounced edge detector with mode-qualified events, sticky status,
// saturating event counters and an OR-reduced interrupt. Optional macro: EDGE_DET_SYNC_EN.
module multi_edge_det #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int DB_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         a_i,
    input  logic [2*NUM_CH-1:0]       mode_i,
    input  logic [DB_W-1:0]           debounce_i,
    input  logic [NUM_CH-1:0]         clr_i,
    output logic [NUM_CH-1:0]         rising_edge,
    output logic [NUM_CH-1:0]         falling_edge,
    output logic [NUM_CH-1:0]         event_o,
    output logic [NUM_CH-1:0]         status_o,
    output logic [NUM_CH*CNT_W-1:0]   count_o,
    output logic                      irq_o
);

    logic [NUM_CH-1:0] w_sample;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             r_filt;
            logic             r_filt_q;
            logic [DB_W-1:0]  r_db_cnt;
            logic             r_status;
            logic [CNT_W-1:0] r_count;

`ifdef EDGE_DET_SYNC_EN
            logic r_sync1;
            logic r_sync2;

            // Reset preloads the raw level so release does not look like a transition.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sync1 <= a_i[gi];
                    r_sync2 <= a_i[gi];
                end else begin
                    r_sync1 <= a_i[gi];
                    r_sync2 <= r_sync1;
                end
            end
            assign w_sample[gi] = r_sync2;
`else
            assign w_sample[gi] = a_i[gi];
`endif

            // Threshold compare uses >= so lowering debounce_i mid-count takes effect at once.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_filt   <= a_i[gi];
                    r_filt_q <= a_i[gi];
                    r_db_cnt <= '0;
                end else begin
                    r_filt_q <= r_filt;
                    if (w_sample[gi] == r_filt) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt >= debounce_i) begin
                        r_filt   <= w_sample[gi];
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
            end

            assign rising_edge[gi]  = r_filt & ~r_filt_q;
            assign falling_edge[gi] = ~r_filt & r_filt_q;
            assign event_o[gi]      = (rising_edge[gi]  & mode_i[2*gi]) |
                                      (falling_edge[gi] & mode_i[2*gi+1]);

            // An event in the same cycle as a clear wins and restarts the count at one.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_status <= 1'b0;
                    r_count  <= '0;
                end else if (event_o[gi]) begin
                    r_status <= 1'b1;
                    if (clr_i[gi]) begin
                        r_count <= CNT_W'(1);
                    end else if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end else if (clr_i[gi]) begin
                    r_status <= 1'b0;
                    r_count  <= '0;
                end
            end

            assign status_o[gi]                 = r_status;
            assign count_o[gi*CNT_W +: CNT_W]   = r_count;
        end
    endgenerate

    assign irq_o = |status_o;

endmodule

// File: tb/tb_multi_edge_det.sv
// Directed bench for multi_edge_det (NUM_CH=4, CNT_W=2, DB_W=4); adapts to EDGE_DET_SYNC_EN latency.
module tb_multi_edge_det;

`ifdef EDGE_DET_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  a_i;
    logic [7:0]  mode_i;
    logic [3:0]  debounce_i;
    logic [3:0]  clr_i;
    logic [3:0]  rising_edge;
    logic [3:0]  falling_edge;
    logic [3:0]  event_o;
    logic [3:0]  status_o;
    logic [7:0]  count_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    multi_edge_det #(.NUM_CH(4), .CNT_W(2), .DB_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_i          (a_i),
        .mode_i       (mode_i),
        .debounce_i   (debounce_i),
        .clr_i        (clr_i),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .event_o      (event_o),
        .status_o     (status_o),
        .count_o      (count_o),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0; a_i = 4'h0; mode_i = 8'h00; debounce_i = 4'd0; clr_i = 4'h0;
        tick(2);
        check("reset_status", 32'(status_o), 32'h0);
        check("reset_count", 32'(count_o), 32'h0);
        reset = 1'b1;
        tick(1);
        check("release_rise", 32'(rising_edge), 32'h0);
        check("release_fall", 32'(falling_edge), 32'h0);
        check("release_irq", 32'(irq_o), 32'h0);

        // Basic rising event on ch0, N=0
        mode_i = 8'h01; a_i = 4'h1;
        tick(1 + LAT);
        check("ch0_rise_pulse", 32'(rising_edge), 32'h1);
        check("ch0_event", 32'(event_o), 32'h1);
        tick(1);
        check("ch0_rise_gone", 32'(rising_edge), 32'h0);
        check("ch0_status", 32'(status_o), 32'h1);
        check("ch0_count", 32'(count_o), 32'h01);
        check("ch0_irq", 32'(irq_o), 32'h1);
        clr_i = 4'h1; tick(1); clr_i = 4'h0;
        check("ch0_clr_status", 32'(status_o), 32'h0);
        check("ch0_clr_count", 32'(count_o), 32'h0);
        check("ch0_clr_irq", 32'(irq_o), 32'h0);

        // Debounce N=3 on ch1: 3-sample glitch rejected, 4-sample level accepted
        mode_i = 8'h00; debounce_i = 4'd3;
        a_i = 4'h3;
        for (int i = 0; i < 3; i++) begin tick(1); check("glitch_hi", 32'(rising_edge), 32'h0); end
        a_i = 4'h1;
        for (int i = 0; i < 3 + LAT; i++) begin tick(1); check("glitch_lo", 32'(rising_edge), 32'h0); end
        a_i = 4'h3;
        for (int i = 0; i < 3 + LAT; i++) begin tick(1); check("hold_wait", 32'(rising_edge), 32'h0); end
        tick(1);
        check("hold_rise", 32'(rising_edge), 32'h2);
        check("mode_off_event", 32'(event_o), 32'h0);
        tick(1);
        check("hold_rise_once", 32'(rising_edge), 32'h0);

        // Lowering the threshold mid-count takes effect against the current count
        a_i = 4'h1;
        tick(2 + LAT);
        check("db_midcount_wait", 32'(falling_edge), 32'h0);
        debounce_i = 4'd1;
        tick(1);
        check("db_lowered_fall", 32'(falling_edge), 32'h2);
        debounce_i = 4'd0;
        tick(1);

        // ch2 both edges: five toggles saturate the 2-bit counter at 3
        mode_i = 8'h30;
        a_i = 4'h5;
        tick(1 + LAT);
        check("ch2_first_event", 32'(event_o), 32'h4);
        for (int i = 0; i < 4; i++) begin a_i[2] = ~a_i[2]; tick(1); end
        tick(1);
        check("ch2_sat_count", 32'(count_o), 32'h30);
        check("ch2_status", 32'(status_o), 32'h4);
        check("ch2_irq", 32'(irq_o), 32'h1);
        clr_i = 4'h4; tick(1); clr_i = 4'h0;
        check("ch2_clr_count", 32'(count_o), 32'h0);
        check("ch2_clr_status", 32'(status_o), 32'h0);
        check("ch2_clr_irq", 32'(irq_o), 32'h0);

        // ch3: build count to 2, then clear coincident with an event
        mode_i = 8'hC0; a_i = 4'hD;
        tick(1 + LAT);
        a_i = 4'h5;
        tick(1);
        tick(1);
        check("ch3_count2", 32'(count_o), 32'h80);
        mode_i = 8'h40; a_i = 4'hD;
        tick(1 + LAT);
        check("ch3_event", 32'(event_o), 32'h8);
        clr_i = 4'h8; tick(1); clr_i = 4'h0;
        check("ch3_clr_evt_status", 32'(status_o), 32'h8);
        check("ch3_clr_evt_count", 32'(count_o), 32'h40);

        // Reset with all inputs high: no spurious edges on release
        reset = 1'b0; a_i = 4'hF; mode_i = 8'h00;
        tick(2);
        check("rst2_count", 32'(count_o), 32'h0);
        check("rst2_status", 32'(status_o), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst2_no_rise", 32'(rising_edge), 32'h0);
            check("rst2_no_fall", 32'(falling_edge), 32'h0);
        end
        mode_i = 8'h01; a_i = 4'hE;
        tick(1 + LAT);
        check("rst2_fall", 32'(falling_edge), 32'h1);
        check("rst2_rise_mode_evt", 32'(event_o), 32'h0);
        mode_i = 8'h02;
        #1;
        check("mode_switch_evt", 32'(event_o), 32'h1);
        tick(1);
        check("mode_switch_status", 32'(status_o), 32'h1);
        check("mode_switch_irq", 32'(irq_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_edge_det.md
MULTI_EDGE_DET -- requirements
Module: multi_edge_det

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of each per-channel event counter (2..16).
REQ-003 Parameter DB_W, default 4, width of the debounce threshold input.
REQ-004 clk  in  1  sole clock; all flops update on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block.
REQ-006 a_i  in  NUM_CH  asynchronous-tolerant input levels, one bit per channel.
REQ-007 mode_i  in  2*NUM_CH  per-channel event select, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 debounce_i  in  DB_W  stability threshold N, shared by all channels.
REQ-009 clr_i  in  NUM_CH  write-1-to-clear pulse for channel status and counter.
REQ-010 rising_edge  out  NUM_CH  one-cycle pulse per filtered rising transition, not mode-qualified.
REQ-011 falling_edge  out  NUM_CH  one-cycle pulse per filtered falling transition, not mode-qualified.
REQ-012 event_o  out  NUM_CH  rising_edge/falling_edge qualified by mode_i.
REQ-013 status_o  out  NUM_CH  sticky per-channel event flag.
REQ-014 count_o  out  NUM_CH*CNT_W  per-channel event counters, channel c at [c*CNT_W +: CNT_W].
REQ-015 irq_o  out  1  OR-reduction of status_o.

Function
REQ-016 Per channel, a filter register filt holds the accepted level; a counter tracks consecutive samples differing from filt.
REQ-017 Sample equal to filt: counter cleared. Sample differing: counter increments; when counter equals N, filt takes the sample and counter clears on the same edge.
REQ-018 N=0: filt follows the sample on the first differing edge; N=k: filt updates on the (k+1)th consecutive differing sample; an intervening equal sample restarts the count.
REQ-019 A filt_q register holds filt delayed by one cycle; rising_edge = filt & ~filt_q, falling_edge = ~filt & filt_q; each pulse lasts exactly one cycle.
REQ-020 Latency with EDGE_DET_SYNC_EN undefined and N=0: a_i change sampled at edge k -> edge pulse high from edge k to edge k+1.
REQ-021 event_o is combinationally qualified by current mode_i; a mode change takes effect in the same cycle.
REQ-022 event_o high -> status_o set on the next edge; counter increments by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-023 clr_i high alone -> status_o and count cleared on the next edge.
REQ-024 clr_i and event_o high in the same cycle -> status_o=1 and count=1 after the edge (event wins over clear).
REQ-025 Channels are fully independent; simultaneous events on several channels are all recorded.
REQ-026 debounce_i changes mid-count apply immediately against the current counter; counter>=N counts as reached.

Reset
REQ-027 During reset, synchronizer flops, filt and filt_q load the raw a_i so no spurious edge appears after release.
REQ-028 Debounce counters, status_o and count_o reset to 0; rising_edge, falling_edge, event_o and irq_o are 0 in the first cycle after release.
REQ-029 Reset asserted mid-debounce discards the partial count; the next transition is measured from release.

Configuration
REQ-030 Macro EDGE_DET_SYNC_EN defined: a two-flop synchronizer per channel precedes the filter, adding exactly 2 cycles of latency.
REQ-031 EDGE_DET_SYNC_EN undefined: a_i drives the filter directly; all other behaviour is identical.

Verification
REQ-032 NUM_CH=4, sync off, N=0, mode=01 on ch0, a_i[0] 0->1 -> rising_edge[0], event_o[0] 1 cycle; status_o[0]=1, count=1, irq_o=1.
REQ-033 N=3, a_i[1] glitch high for 3 cycles -> no edge; held 4 cycles -> exactly one rising_edge[1] 4 cycles after first high sample.
REQ-034 CNT_W=2, mode=11, 5 toggles on ch2 -> count saturates at 3; clr_i[2] -> count 0, status 0, irq_o 0.
REQ-035 clr_i[3] in same cycle as event_o[3] -> status_o[3]=1, count=1.
REQ-036 Reset with a_i=4'hF, release -> no edge pulses; then a_i[0] falls, mode=01 -> falling_edge[0] pulses, event_o[0]=0.
REQ-037 EDGE_DET_SYNC_EN defined, rerun REQ-032 -> identical response delayed by exactly 2 cycles.
